// File: rtl/acc_arbiter.sv
// Two-requester round-robin accumulator with a four-phase handshake.
// Define ACC_SAT_EN to saturate on overflow instead of wrapping.
module acc_arbiter #(
   parameter int OPW  = 5,
   parameter int SUMW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0,
   input  logic [OPW-1:0]  op0,
   input  logic            req1,
   input  logic [OPW-1:0]  op1,
   input  logic            clr,
   output logic            ack0,
   output logic            ack1,
   output logic [SUMW-1:0] sum,
   output logic            busy,
   output logic            ovf
);

   typedef enum logic [1:0] {IDLE, ADD, ACK, WAIT_REL} state_t;

   state_t          state, state_nxt;
   logic            gnt_id, gnt_id_nxt;
   logic            last, last_nxt;
   logic [OPW-1:0]  opl, opl_nxt;
   logic [SUMW-1:0] sum_nxt;
   logic            ovf_nxt;
   logic [SUMW:0]   total;
   logic            win;

`ifdef ACC_SAT_EN
   localparam logic [SUMW-1:0] SUM_MAX = '1;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         gnt_id <= 1'b0;
         last   <= 1'b1;   // req0 wins the first tie
         opl    <= '0;
         sum    <= '0;
         ovf    <= 1'b0;
      end else begin
         state  <= state_nxt;
         gnt_id <= gnt_id_nxt;
         last   <= last_nxt;
         opl    <= opl_nxt;
         sum    <= sum_nxt;
         ovf    <= ovf_nxt;
      end
   end

   // On a tie the requester not granted last time wins.
   assign win = (req0 && req1) ? ~last : req1;

   always_comb begin
      state_nxt  = state;
      gnt_id_nxt = gnt_id;
      last_nxt   = last;
      opl_nxt    = opl;
      ack0       = 1'b0;
      ack1       = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt  = ADD;
               gnt_id_nxt = win;
               last_nxt   = win;
               opl_nxt    = win ? op1 : op0;
            end
         end
         ADD: state_nxt = ACK;
         ACK: begin
            state_nxt = WAIT_REL;
            ack0      = ~gnt_id;
            ack1      = gnt_id;
         end
         WAIT_REL: begin
            if (!(gnt_id ? req1 : req0))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign total = {1'b0, sum} + (SUMW+1)'(opl);

   // clr has priority over an add landing in the same cycle.
   always_comb begin
      sum_nxt = sum;
      ovf_nxt = ovf;
      if (clr) begin
         sum_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (state == ADD) begin
         if (total[SUMW]) begin
            ovf_nxt = 1'b1;
`ifdef ACC_SAT_EN
            sum_nxt = SUM_MAX;
`else
            sum_nxt = total[SUMW-1:0];
`endif
         end else begin
            sum_nxt = total[SUMW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed plus randomized bench for acc_arbiter against a transaction-level model.
module tb_acc_arbiter;
   localparam int OPW  = 5;
   localparam int SUMW = 8;
   localparam int MAXS = (1 << SUMW) - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req0 = 1'b0, req1 = 1'b0, clr = 1'b0;
   logic [OPW-1:0]  op0 = '0, op1 = '0;
   logic            ack0, ack1, busy, ovf;
   logic [SUMW-1:0] sum;

   int vecs = 0;
   int errs = 0;

   // model: a transaction is active from grant until release; age counts edges since grant
   bit             m_act, m_who, m_last, m_ovf;
   int             m_age, m_sum;
   logic [OPW-1:0] m_op;

   acc_arbiter #(.OPW(OPW), .SUMW(SUMW)) dut (
      .clk(clk), .rst(rst), .req0(req0), .op0(op0), .req1(req1), .op1(op1),
      .clr(clr), .ack0(ack0), .ack1(ack1), .sum(sum), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int t;
      if (!rst) begin
         m_act = 0; m_age = 0; m_last = 1; m_sum = 0; m_ovf = 0;
      end else begin
         if (m_act && m_age == 1 && !clr) begin
            t = m_sum + int'(m_op);
            if (t > MAXS) begin
               m_ovf = 1;
`ifdef ACC_SAT_EN
               m_sum = MAXS;
`else
               m_sum = t - (MAXS + 1);
`endif
            end else m_sum = t;
         end else if (clr) begin
            m_sum = 0; m_ovf = 0;
         end
         if (!m_act) begin
            if (req0 || req1) begin
               m_who  = (req0 && req1) ? !m_last : req1;
               m_last = m_who;
               m_op   = m_who ? op1 : op0;
               m_act  = 1; m_age = 1;
            end
         end else if (m_age < 3) m_age++;
         else if (!(m_who ? req1 : req0)) m_act = 0;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk); #1;
      chk("ack0", 32'(ack0), 32'(m_act && m_age == 2 && !m_who));
      chk("ack1", 32'(ack1), 32'(m_act && m_age == 2 && m_who));
      chk("busy", 32'(busy), 32'(m_act));
      chk("sum",  32'(sum),  32'(m_sum));
      chk("ovf",  32'(ovf),  32'(m_ovf));
   endtask

   task automatic do_reset();
      rst = 0; req0 = 0; req1 = 0; clr = 0;
      step(); step();
      rst = 1;
   endtask

   task automatic wait_ack(input bit who, output int lat);
      lat = -1;
      for (int n = 1; n <= 8 && lat < 0; n++) begin
         step();
         if (who ? ack1 : ack0) lat = n;
      end
      chk(who ? "ack1_timeout" : "ack0_timeout", 32'(lat > 0), 32'd1);
   endtask

   task automatic do_add(input bit who, input int op, output int lat, output int nbusy);
      lat = -1; nbusy = 0;
      if (who) begin req1 = 1; op1 = OPW'(op); end
      else     begin req0 = 1; op0 = OPW'(op); end
      for (int n = 1; n <= 8 && lat < 0; n++) begin
         step();
         if (busy) nbusy++;
         op0 = OPW'($urandom); op1 = OPW'($urandom);   // must not disturb the add in flight
         if (who ? ack1 : ack0) lat = n;
      end
      chk("add_ack_timeout", 32'(lat > 0), 32'd1);
      if (who) req1 = 0; else req0 = 0;
      for (int n = 0; n < 8 && busy; n++) begin
         step();
         if (busy) nbusy++;
      end
      chk("add_idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      int lat, nb, cnt;
      bit v;

      do_reset();
      chk("rst_sum", 32'(sum), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_ack", 32'({ack1, ack0}), 0);

      // single requester latency and busy width
      do_add(0, 7, lat, nb);
      chk("r0_lat", 32'(lat), 2);
      chk("r0_sum", 32'(sum), 7);
      chk("r0_busy_cycles", 32'(nb), 3);

      // ties: req0 first after reset, then req1 wins a tie after req0 was last granted
      do_reset();
      req0 = 1; req1 = 1; op0 = 3; op1 = 4;
      wait_ack(0, lat);
      chk("tie1_lat", 32'(lat), 2);
      chk("tie1_ack1", 32'(ack1), 0);
      chk("tie1_sum", 32'(sum), 3);
      req0 = 0;
      step(); step();
      req0 = 1; op0 = 3;
      wait_ack(1, lat);
      chk("tie2_lat", 32'(lat), 2);
      chk("tie2_ack0", 32'(ack0), 0);
      chk("tie2_sum", 32'(sum), 7);
      req1 = 0;
      wait_ack(0, lat);
      chk("tie3_sum", 32'(sum), 10);
      req0 = 0;
      step(); step(); step();

      // overflow
      do_reset();
      for (int i = 0; i < 8; i++) do_add(i[0], 31, lat, nb);
      do_add(1, 2, lat, nb);
      chk("pre_ovf_sum", 32'(sum), 250);
      chk("pre_ovf_flag", 32'(ovf), 0);
      do_add(0, 10, lat, nb);
`ifdef ACC_SAT_EN
      chk("ovf_sum", 32'(sum), 255);
`else
      chk("ovf_sum", 32'(sum), 4);
`endif
      chk("ovf_flag", 32'(ovf), 1);
      do_add(1, 1, lat, nb);
`ifdef ACC_SAT_EN
      chk("ovf2_sum", 32'(sum), 255);
`else
      chk("ovf2_sum", 32'(sum), 5);
`endif
      chk("ovf_sticky", 32'(ovf), 1);

      // clr during ADD discards the add but keeps the ack
      do_reset();
      do_add(0, 20, lat, nb);
      chk("clr_pre_sum", 32'(sum), 20);
      req1 = 1; op1 = 5;
      step();
      clr = 1; op1 = OPW'($urandom);
      step();
      clr = 0;
      chk("clr_ack1", 32'(ack1), 1);
      chk("clr_sum", 32'(sum), 0);
      chk("clr_ovf", 32'(ovf), 0);
      req1 = 0; cnt = 0;
      for (int i = 0; i < 5; i++) begin step(); if (ack1) cnt++; end
      chk("clr_ack1_once", 32'(cnt), 0);

      // reset during ACK aborts the transaction
      do_reset();
      req0 = 1; op0 = 9;
      step(); step();
      chk("rstack_ack0", 32'(ack0), 1);
      rst = 0; req0 = 0;
      step();
      chk("rstack_sum", 32'(sum), 0);
      chk("rstack_busy", 32'(busy), 0);
      rst = 1; cnt = 0;
      for (int i = 0; i < 5; i++) begin step(); if (ack0) cnt++; end
      chk("rstack_no_ack", 32'(cnt), 0);

      // held request is acked once only
      req0 = 1; op0 = 6;
      wait_ack(0, lat);
      cnt = 1; v = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ack0) cnt++;
         if (!busy) v = 0;
      end
      chk("hold_busy", 32'(v), 1);
      req0 = 0;
      step(); step();
      chk("hold_acks", 32'(cnt), 1);
      chk("hold_sum", 32'(sum), 6);
      chk("hold_idle", 32'(busy), 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req0 = ~req0;
         if ($urandom_range(0, 3) == 0) req1 = ~req1;
         op0 = OPW'($urandom);
         op1 = OPW'($urandom);
         clr = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 59) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
